// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencing controller.
// Contents:
//   - FSM state codes (also visible on the debug 'state' port)
//   - ALUOp codes understood by the shared ALU
//   - supported opcode values
//   - RegDst / ALUSrcB / PCSource mux select values
//   - ctrl_t, the packed control word the FSM decodes each cycle
package mc_pkg;

    // FSM state codes
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // RegDst selects
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PCSource selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ext_mode;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // States that sit on the memory port waiting for mem_ready
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog for the multi-cycle controller.
// Counts cycles spent stalled on the memory port and flags a timeout in the
// cycle the stall count reaches MEM_TIMEOUT (0 disables the watchdog).
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   waiting     - FSM is in a state that waits on mem_ready
//   mem_ready   - memory handshake; a ready cycle never times out
//   advance     - FSM changes state this cycle (clears the count)
//   timeout     - combinational: this stalled cycle is the limit
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    input  logic advance,
    output logic timeout
);

    localparam logic [8:0] LIMIT = 9'(MEM_TIMEOUT);

    logic [7:0] count;
    logic       stalled;

    assign stalled = waiting && !mem_ready;

    // Stall counter; saturates so a disabled watchdog never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (advance) begin
            count <= 8'd0;
        end else if (stalled && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // The current stalled cycle is counted, so the limit is hit when the
    // stored count plus this cycle equals MEM_TIMEOUT.
    assign timeout = (MEM_TIMEOUT != 0) && stalled &&
                     (({1'b0, count} + 9'd1) == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller (Moore FSM).
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB so a single ALU and
// a unified memory port are shared across cycles.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   op             - opcode from the instruction register
//   zero           - ALU zero flag (branch resolution)
//   mem_ready      - memory access completes this cycle
//   pc_write .. PCSource - datapath enables and mux selects
//   instr_done     - pulse on the last cycle of each instruction
//   illegal        - sticky, unsupported opcode trapped
//   bus_err        - sticky, mem_ready timeout
//   state          - current state code for debug
module multicycle_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic       MemtoReg,
    output logic       PCToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       ExtMode,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    logic [3:0] next_state;
    logic       timeout;
    logic       waiting;
    logic       advance;
    ctrl_t      ctrl;

    assign waiting = is_wait_state(state);
    assign advance = (next_state != state);

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .waiting   (waiting),
        .mem_ready (mem_ready),
        .advance   (advance),
        .timeout   (timeout)
    );

    // State register plus the two sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= next_state;
            illegal <= illegal | ((state == S_DECODE) && (next_state == S_TRAP));
            bus_err <= bus_err | timeout;
        end
    end

    // Next-state logic. A ready handshake is checked before the timeout so a
    // late-but-in-time mem_ready still completes the access.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                   next_state = S_EXEC_R;
                    OP_LW, OP_SW:               next_state = S_MEMADR;
                    OP_BEQ, OP_BNE:             next_state = S_BRANCH;
                    OP_JAL:                     next_state = S_JAL;
                    OP_ANDI, OP_XORI, OP_SLTI:  next_state = S_EXEC_I;
                    default:                    next_state = S_TRAP;
                endcase
            end
            S_MEMADR: next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)    next_state = S_MEMWB;
                else if (timeout) next_state = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_TRAP;
            end
            S_EXEC_R, S_EXEC_I:                   next_state = S_ALUWB;
            S_ALUWB, S_MEMWB, S_BRANCH, S_JAL:    next_state = S_FETCH;
            S_TRAP:                               next_state = S_TRAP;
            default:                              next_state = S_TRAP;
        endcase
    end

    // Control decode. Everything defaults to 0 so unused selects never float.
    // A timeout cycle and reset both suppress the whole word's enables.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.ext_mode  = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (op)
                    OP_ANDI: begin
                        ctrl.alu_op   = ALU_ADD;
                        ctrl.ext_mode = 1'b0;
                    end
                    OP_XORI: begin
                        ctrl.alu_op   = ALU_XOR;
                        ctrl.ext_mode = 1'b0;
                    end
                    OP_SLTI: begin
                        ctrl.alu_op   = ALU_SLT;
                        ctrl.ext_mode = 1'b1;
                    end
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                ctrl.instr_done = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_mode  = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.pc_write   = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.reg_dst    = REGDST_RA;
                ctrl.pc_to_reg  = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase

        if (timeout) begin
            ctrl.pc_write  = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
        end

        if (reset) begin
            ctrl = '0;
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign IorD       = ctrl.iord;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign PCToReg    = ctrl.pc_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign ExtMode    = ctrl.ext_mode;
    assign PCSource   = ctrl.pc_source;
    assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT = 4).
// Each cycle pushes the expected control word into a scoreboard queue as the
// inputs are driven; the word is popped and compared mid-cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst;
    logic       MemtoReg, PCToReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic       ExtMode;
    logic [1:0] PCSource;
    logic       instr_done, illegal, bus_err;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCToReg(PCToReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtMode(ExtMode), .PCSource(PCSource), .instr_done(instr_done),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    // Enables: {pc_write, MemRead, MemWrite, IRWrite, RegWrite, instr_done}
    localparam logic [5:0] EN_NONE   = 6'b000000;
    localparam logic [5:0] EN_FETCH  = 6'b110100;
    localparam logic [5:0] EN_MRWAIT = 6'b010000;
    localparam logic [5:0] EN_WB     = 6'b000011;
    localparam logic [5:0] EN_WR     = 6'b001000;
    localparam logic [5:0] EN_WRDONE = 6'b001001;
    localparam logic [5:0] EN_BR_T   = 6'b100001;
    localparam logic [5:0] EN_BR_N   = 6'b000001;
    localparam logic [5:0] EN_JAL    = 6'b100011;

    // Selects: {IorD, RegDst, MemtoReg, PCToReg, ALUSrcA, ALUSrcB, ALUOp, ExtMode, PCSource}
    localparam logic [14:0] SEL_ZERO   = 15'b0_00_0_0_0_00_0000_0_00;
    localparam logic [14:0] SEL_FETCH  = 15'b0_00_0_0_0_01_0000_0_00;
    localparam logic [14:0] SEL_DECODE = 15'b0_00_0_0_0_11_0000_1_00;
    localparam logic [14:0] SEL_EXECR  = 15'b0_00_0_0_1_00_0010_0_00;
    localparam logic [14:0] SEL_ANDI   = 15'b0_00_0_0_1_10_0000_0_00;
    localparam logic [14:0] SEL_XORI   = 15'b0_00_0_0_1_10_0011_0_00;
    localparam logic [14:0] SEL_SLTI   = 15'b0_00_0_0_1_10_0100_1_00;
    localparam logic [14:0] SEL_WB_R   = 15'b0_01_0_0_0_00_0000_0_00;
    localparam logic [14:0] SEL_MEMADR = 15'b0_00_0_0_1_10_0000_1_00;
    localparam logic [14:0] SEL_MEMACC = 15'b1_00_0_0_0_00_0000_0_00;
    localparam logic [14:0] SEL_MEMWB  = 15'b0_00_1_0_0_00_0000_0_00;
    localparam logic [14:0] SEL_BRANCH = 15'b0_00_0_0_1_00_0001_0_01;
    localparam logic [14:0] SEL_JAL    = 15'b0_10_0_1_0_00_0000_0_10;

    // Flags: {illegal, bus_err}
    localparam logic [1:0] F_OK  = 2'b00;
    localparam logic [1:0] F_ILL = 2'b10;
    localparam logic [1:0] F_BUS = 2'b01;

    typedef struct {
        logic [3:0]  st;
        logic [5:0]  en;
        logic [14:0] sel;
        logic [1:0]  fl;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [5:0]  obs_en;
    logic [14:0] obs_sel;
    logic [1:0]  obs_fl;
    assign obs_en  = {pc_write, MemRead, MemWrite, IRWrite, RegWrite, instr_done};
    assign obs_sel = {IorD, RegDst, MemtoReg, PCToReg, ALUSrcA, ALUSrcB, ALUOp, ExtMode, PCSource};
    assign obs_fl  = {illegal, bus_err};

    task automatic push_exp(input string tag, input logic [3:0] st, input logic [5:0] en,
                            input logic [14:0] sel, input logic [1:0] fl);
        exp_t e;
        e.st = st; e.en = en; e.sel = sel; e.fl = fl; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (state === e.st) else begin
                failures++;
                $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
            end
            checks++;
            assert (obs_en === e.en) else begin
                failures++;
                $error("FAIL %s.enables observed=%b expected=%b", e.tag, obs_en, e.en);
            end
            checks++;
            assert (obs_sel === e.sel) else begin
                failures++;
                $error("FAIL %s.selects observed=%b expected=%b", e.tag, obs_sel, e.sel);
            end
            checks++;
            assert (obs_fl === e.fl) else begin
                failures++;
                $error("FAIL %s.flags observed=%b expected=%b", e.tag, obs_fl, e.fl);
            end
        end
    endtask

    // One clocked cycle: called just after a rising edge.
    task automatic applyStimulus(input string tag, input logic [5:0] o, input logic z,
                                 input logic mr, input logic [3:0] st, input logic [5:0] en,
                                 input logic [14:0] sel, input logic [1:0] fl);
        op = o; zero = z; mem_ready = mr;
        push_exp(tag, st, en, sel, fl);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Assert reset for one cycle from just after a rising edge, check it, release.
    task automatic reset_check(input string tag);
        reset = 1'b1;
        mem_ready = 1'b1;
        push_exp(tag, 4'd0, EN_NONE, SEL_ZERO, F_OK);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] o);
        applyStimulus({tag, "_fetch"},  o, 1'b0, 1'b1, 4'd0, EN_FETCH, SEL_FETCH, F_OK);
        applyStimulus({tag, "_decode"}, o, 1'b0, 1'b0, 4'd1, EN_NONE, SEL_DECODE, F_OK);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        reset_check("reset");

        // R-type with mem_ready tied high: 0,1,6,8
        applyStimulus("r_fetch",  6'b000000, 1'b0, 1'b1, 4'd0, EN_FETCH, SEL_FETCH, F_OK);
        applyStimulus("r_decode", 6'b000000, 1'b0, 1'b1, 4'd1, EN_NONE,  SEL_DECODE, F_OK);
        applyStimulus("r_exec",   6'b000000, 1'b0, 1'b1, 4'd6, EN_NONE,  SEL_EXECR, F_OK);
        applyStimulus("r_wb",     6'b000000, 1'b0, 1'b1, 4'd8, EN_WB,    SEL_WB_R, F_OK);

        // I-type variants
        fetch_decode("andi", 6'b001100);
        applyStimulus("andi_exec", 6'b001100, 1'b1, 1'b0, 4'd7, EN_NONE, SEL_ANDI, F_OK);
        applyStimulus("andi_wb",   6'b001100, 1'b1, 1'b0, 4'd8, EN_WB,   SEL_ZERO, F_OK);
        fetch_decode("xori", 6'b001110);
        applyStimulus("xori_exec", 6'b001110, 1'b0, 1'b0, 4'd7, EN_NONE, SEL_XORI, F_OK);
        applyStimulus("xori_wb",   6'b001110, 1'b0, 1'b0, 4'd8, EN_WB,   SEL_ZERO, F_OK);
        fetch_decode("slti", 6'b001010);
        applyStimulus("slti_exec", 6'b001010, 1'b0, 1'b0, 4'd7, EN_NONE, SEL_SLTI, F_OK);
        applyStimulus("slti_wb",   6'b001010, 1'b0, 1'b0, 4'd8, EN_WB,   SEL_ZERO, F_OK);

        // lw with three stalled MEMRD cycles: 8 cycles total
        fetch_decode("lw", 6'b100011);
        applyStimulus("lw_adr", 6'b100011, 1'b0, 1'b0, 4'd2, EN_NONE, SEL_MEMADR, F_OK);
        for (int i = 0; i < 3; i++)
            applyStimulus("lw_rdwait", 6'b100011, 1'b0, 1'b0, 4'd3, EN_MRWAIT, SEL_MEMACC, F_OK);
        applyStimulus("lw_rd", 6'b100011, 1'b0, 1'b1, 4'd3, EN_MRWAIT, SEL_MEMACC, F_OK);
        applyStimulus("lw_wb", 6'b100011, 1'b0, 1'b0, 4'd4, EN_WB,     SEL_MEMWB, F_OK);

        // sw: two stalled fetch cycles, then ready arrives on the 4th MEMWR
        // cycle, exactly at the timeout boundary, and must still complete
        applyStimulus("sw_fwait0", 6'b101011, 1'b0, 1'b0, 4'd0, EN_MRWAIT, SEL_FETCH, F_OK);
        applyStimulus("sw_fwait1", 6'b101011, 1'b0, 1'b0, 4'd0, EN_MRWAIT, SEL_FETCH, F_OK);
        fetch_decode("sw", 6'b101011);
        applyStimulus("sw_adr", 6'b101011, 1'b0, 1'b0, 4'd2, EN_NONE, SEL_MEMADR, F_OK);
        for (int i = 0; i < 3; i++)
            applyStimulus("sw_wrwait", 6'b101011, 1'b0, 1'b0, 4'd5, EN_WR, SEL_MEMACC, F_OK);
        applyStimulus("sw_wrdone", 6'b101011, 1'b0, 1'b1, 4'd5, EN_WRDONE, SEL_MEMACC, F_OK);

        // Branches
        fetch_decode("bne_z0", 6'b000101);
        applyStimulus("bne_z0_br", 6'b000101, 1'b0, 1'b0, 4'd9, EN_BR_T, SEL_BRANCH, F_OK);
        fetch_decode("bne_z1", 6'b000101);
        applyStimulus("bne_z1_br", 6'b000101, 1'b1, 1'b0, 4'd9, EN_BR_N, SEL_BRANCH, F_OK);
        fetch_decode("beq_z1", 6'b000100);
        applyStimulus("beq_z1_br", 6'b000100, 1'b1, 1'b0, 4'd9, EN_BR_T, SEL_BRANCH, F_OK);
        fetch_decode("beq_z0", 6'b000100);
        applyStimulus("beq_z0_br", 6'b000100, 1'b0, 1'b0, 4'd9, EN_BR_N, SEL_BRANCH, F_OK);

        // jal: 3 cycles
        fetch_decode("jal", 6'b000011);
        applyStimulus("jal_exec", 6'b000011, 1'b0, 1'b0, 4'd10, EN_JAL, SEL_JAL, F_OK);

        // Reset asserted mid-MEMWR drops MemWrite without waiting for a clock
        fetch_decode("swrst", 6'b101011);
        applyStimulus("swrst_adr", 6'b101011, 1'b0, 1'b0, 4'd2, EN_NONE, SEL_MEMADR, F_OK);
        op = 6'b101011; zero = 1'b0; mem_ready = 1'b0;
        push_exp("swrst_wr", 4'd5, EN_WR, SEL_MEMACC, F_OK);
        @(negedge clk);
        checkOutput();
        #2;
        reset = 1'b1;
        push_exp("swrst_async", 4'd0, EN_NONE, SEL_ZERO, F_OK);
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus("post_rst_fetch", 6'b000000, 1'b0, 1'b0, 4'd0, EN_MRWAIT, SEL_FETCH, F_OK);

        // Illegal opcode: DECODE then TRAP, sticky with all enables off
        applyStimulus("ill_fetch", 6'b111111, 1'b0, 1'b1, 4'd0, EN_FETCH, SEL_FETCH, F_OK);
        applyStimulus("ill_decode", 6'b111111, 1'b0, 1'b1, 4'd1, EN_NONE, SEL_DECODE, F_OK);
        for (int i = 0; i < 10; i++)
            applyStimulus("ill_trap", 6'b111111, i[0], i[1], 4'd11, EN_NONE, SEL_ZERO, F_ILL);
        reset_check("ill_reset");

        // Timeout in FETCH: 4th stalled cycle suppresses MemRead and traps
        for (int i = 0; i < 3; i++)
            applyStimulus("to_wait", 6'b000000, 1'b0, 1'b0, 4'd0, EN_MRWAIT, SEL_FETCH, F_OK);
        applyStimulus("to_limit", 6'b000000, 1'b0, 1'b0, 4'd0, EN_NONE, SEL_FETCH, F_OK);
        applyStimulus("to_trap0", 6'b000000, 1'b0, 1'b1, 4'd11, EN_NONE, SEL_ZERO, F_BUS);
        applyStimulus("to_trap1", 6'b000000, 1'b0, 1'b0, 4'd11, EN_NONE, SEL_ZERO, F_BUS);
        reset_check("to_reset");

        // Normal operation after recovery
        applyStimulus("rec_fetch",  6'b000000, 1'b0, 1'b1, 4'd0, EN_FETCH, SEL_FETCH, F_OK);
        applyStimulus("rec_decode", 6'b000000, 1'b0, 1'b1, 4'd1, EN_NONE,  SEL_DECODE, F_OK);
        applyStimulus("rec_exec",   6'b000000, 1'b0, 1'b1, 4'd6, EN_NONE,  SEL_EXECR, F_OK);
        applyStimulus("rec_wb",     6'b000000, 1'b0, 1'b1, 4'd8, EN_WB,    SEL_WB_R, F_OK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
